// File: rtl/sprite_color_gen_if.sv
// rtl/sprite_color_gen_if.sv - control and frame bus for sprite_color_gen (blink signal present when SMILEY_BLINK_EN is defined)
interface sprite_color_gen_if #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int LFSR_W = 8,
    parameter int HOLD_W = 16
);
    logic                      clk_en;
    logic [1:0]                mode;
    logic [LFSR_W-1:0]         seed;
    logic                      seed_load;
    logic [HOLD_W-1:0]         hold_cycles;
    logic [ROWS*COLS-1:0]      sprite;
`ifdef SMILEY_BLINK_EN
    logic                      blink;
`endif
    logic [ROWS*3*COLS-1:0]    out;
    logic [2:0]                color;
    logic                      frame_stb;

`ifdef SMILEY_BLINK_EN
    modport master (
        output clk_en, mode, seed, seed_load, hold_cycles, sprite, blink,
        input  out, color, frame_stb
    );
    modport slave (
        input  clk_en, mode, seed, seed_load, hold_cycles, sprite, blink,
        output out, color, frame_stb
    );
`else
    modport master (
        output clk_en, mode, seed, seed_load, hold_cycles, sprite,
        input  out, color, frame_stb
    );
    modport slave (
        input  clk_en, mode, seed, seed_load, hold_cycles, sprite,
        output out, color, frame_stb
    );
`endif
endinterface

// File: rtl/sprite_color_gen.sv
// rtl/sprite_color_gen.sv - sprite colour generator for an RGB LED matrix, optional blink via SMILEY_BLINK_EN
module sprite_color_gen #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int LFSR_W = 8,
    parameter int HOLD_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sprite_color_gen_if.slave     bus
);

    localparam logic [1:0] MODE_RANDOM = 2'b00;
    localparam logic [1:0] MODE_CYCLE  = 2'b01;
    localparam logic [1:0] MODE_STATIC = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;
    localparam int         OUT_W       = ROWS * 3 * COLS;

    // Tap positions (1-indexed) folded into a bit mask, bit i = tap i+1.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0] TAPS = tap_mask(LFSR_W);

    generate
        if (TAPS == 16'h0000) begin : g_bad_lfsr_w
            $error("sprite_color_gen: unsupported LFSR_W");
        end
    endgenerate

    // Colour 000 would blank the display, so it is shown as white instead.
    function automatic logic [2:0] cmap(input logic [2:0] x);
        return (x == 3'b000) ? 3'b111 : x;
    endfunction

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [2:0]        color_q, color_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              stb_q, stb_d;
    logic              count_en;
    logic              advance;
    logic              blank;
    logic [HOLD_W:0]   cnt_inc;
    logic [HOLD_W:0]   hold_eff;

`ifdef SMILEY_BLINK_EN
    logic phase_q, phase_d;
`endif

    // Hold counter compare and next LFSR value.
    always_comb begin
        count_en  = bus.clk_en && (bus.mode != MODE_OFF);
        cnt_inc   = {1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, 1'b1};
        hold_eff  = (bus.hold_cycles == '0) ? {{HOLD_W{1'b0}}, 1'b1} : {1'b0, bus.hold_cycles};
        advance   = count_en && (cnt_inc >= hold_eff);
        lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS[LFSR_W-1:0])};
    end

    // Next-state for LFSR, colour, hold counter and strobe; seed load beats advance.
    always_comb begin
        lfsr_d     = lfsr_q;
        color_d    = color_q;
        hold_cnt_d = hold_cnt_q;
        stb_d      = 1'b0;
        if (bus.seed_load) begin
            lfsr_d     = (bus.seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : bus.seed;
            color_d    = cmap(bus.seed[2:0]);
            hold_cnt_d = '0;
        end else if (advance) begin
            hold_cnt_d = '0;
            stb_d      = 1'b1;
            case (bus.mode)
                MODE_RANDOM: begin
                    lfsr_d  = lfsr_step;
                    color_d = cmap(lfsr_step[2:0]);
                end
                MODE_CYCLE:  color_d = (color_q == 3'b111) ? 3'b001 : color_q + 3'b001;
                MODE_STATIC: color_d = color_q;
                default:     color_d = color_q;
            endcase
        end else if (count_en) begin
            hold_cnt_d = hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef SMILEY_BLINK_EN
    // Blink phase flips with every colour advance and restarts on seed load.
    always_comb begin
        phase_d = phase_q;
        if (bus.seed_load) begin
            phase_d = 1'b0;
        end else if (advance) begin
            phase_d = ~phase_q;
        end
        blank = bus.blink && phase_q;
    end
`else
    assign blank = 1'b0;
`endif

    // Frame word: each row gates the sprite row into the R, G and B planes.
    always_comb begin
        out_d = '0;
        if ((bus.mode != MODE_OFF) && !blank) begin
            for (int r = 0; r < ROWS; r++) begin
                out_d[r*3*COLS + 2*COLS +: COLS] = color_q[2] ? bus.sprite[r*COLS +: COLS] : '0;
                out_d[r*3*COLS +   COLS +: COLS] = color_q[1] ? bus.sprite[r*COLS +: COLS] : '0;
                out_d[r*3*COLS          +: COLS] = color_q[0] ? bus.sprite[r*COLS +: COLS] : '0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q     <= {{(LFSR_W-1){1'b0}}, 1'b1};
            color_q    <= 3'b111;
            hold_cnt_q <= '0;
            out_q      <= '0;
            stb_q      <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            color_q    <= color_d;
            hold_cnt_q <= hold_cnt_d;
            out_q      <= out_d;
            stb_q      <= stb_d;
        end
    end

`ifdef SMILEY_BLINK_EN
    // Blink phase register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    assign bus.out       = out_q;
    assign bus.color     = color_q;
    assign bus.frame_stb = stb_q;

endmodule

// File: tb/tb_sprite_color_gen.sv
// tb/tb_sprite_color_gen.sv - self-checking bench for sprite_color_gen
module tb_sprite_color_gen;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int LW   = 8;
    localparam int HW   = 16;
    localparam int OW   = ROWS * 3 * COLS;
    localparam logic [63:0] SMILEY = {8'h3C, 8'h42, 8'hA9, 8'h85, 8'h85, 8'hA9, 8'h42, 8'h3C};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_color_gen_if #(.ROWS(ROWS), .COLS(COLS), .LFSR_W(LW), .HOLD_W(HW)) bus();

    sprite_color_gen #(.ROWS(ROWS), .COLS(COLS), .LFSR_W(LW), .HOLD_W(HW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model
    int          m_lfsr  = 1;
    logic [2:0]  m_color = 3'b111;
    int          m_cnt   = 0;
    logic [OW-1:0] m_out = '0;
    logic        m_stb   = 1'b0;
    logic        m_phase = 1'b0;

    function automatic int lfsr_next(input int v);
        int taps[4] = '{8, 6, 5, 4};
        int fb = 0;
        foreach (taps[k]) fb = fb ^ ((v >> (taps[k] - 1)) & 1);
        return ((v << 1) | fb) & 'hFF;
    endfunction

    function automatic logic [2:0] to_color(input int v);
        return ((v % 8) == 0) ? 3'd7 : 3'(v % 8);
    endfunction

    function automatic logic [OW-1:0] frame_of(input logic [2:0] c, input logic [63:0] sp);
        logic [OW-1:0] f = '0;
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < 3; p++)
                if (c[p]) f[r*24 + p*8 +: 8] = sp[r*8 +: 8];
        return f;
    endfunction

    always @(posedge clk) begin : model
        int   hold;
        logic adv;
        logic blank_now;
        if (!rst_n) begin
            m_lfsr = 1; m_color = 3'b111; m_cnt = 0; m_out = '0; m_stb = 1'b0; m_phase = 1'b0;
        end else begin
            hold = (bus.hold_cycles == 0) ? 1 : int'(bus.hold_cycles);
            adv  = bus.clk_en && bus.mode != 2'b11 && (m_cnt + 1 >= hold);
`ifdef SMILEY_BLINK_EN
            blank_now = bus.blink && m_phase;
`else
            blank_now = 1'b0;
`endif
            m_out = (bus.mode == 2'b11 || blank_now) ? '0 : frame_of(m_color, bus.sprite);
            if (bus.seed_load) begin
                m_lfsr  = (bus.seed == 0) ? 1 : int'(bus.seed);
                m_color = to_color(int'(bus.seed));
                m_cnt   = 0;
                m_stb   = 1'b0;
                m_phase = 1'b0;
            end else if (adv) begin
                m_cnt   = 0;
                m_stb   = 1'b1;
                m_phase = ~m_phase;
                if (bus.mode == 2'b00) begin
                    m_lfsr  = lfsr_next(m_lfsr);
                    m_color = to_color(m_lfsr);
                end else if (bus.mode == 2'b01) begin
                    m_color = (m_color == 3'd7) ? 3'd1 : m_color + 3'd1;
                end
            end else begin
                m_stb = 1'b0;
                if (bus.clk_en && bus.mode != 2'b11) m_cnt = m_cnt + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("out", bus.out, m_out);
            check("color", OW'(bus.color), OW'(m_color));
            check("frame_stb", OW'(bus.frame_stb), OW'(m_stb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [2:0] cyc_exp [4] = '{3'd5, 3'd6, 3'd7, 3'd1};
        logic [2:0] rnd_col [4] = '{3'd2, 3'd4, 3'd7, 3'd1};
        int         rnd_lfsr[4] = '{'h02, 'h04, 'h08, 'h11};
        int got, dbl, blanks;
        logic prev;

        bus.clk_en = 1'b0; bus.mode = 2'b10; bus.seed = 8'h05; bus.seed_load = 1'b1;
        bus.hold_cycles = 16'd1; bus.sprite = SMILEY;
`ifdef SMILEY_BLINK_EN
        bus.blink = 1'b0;
`endif
        rst_n = 1'b0;
        tick(); chk_on = 1'b1;
        tick(); tick();
        check("reset_out", bus.out, '0);
        check("reset_color", OW'(bus.color), OW'(3'b111));
        check("reset_stb", OW'(bus.frame_stb), '0);

        rst_n = 1'b1; bus.seed_load = 1'b0;
        tick();
        check("first_frame_row0", OW'(bus.out[23:0]), OW'(24'h3C3C3C));

        // RANDOM from seed 1, advance every enabled cycle
        bus.seed = 8'h01; bus.seed_load = 1'b1;
        tick();
        check("rnd_load_color", OW'(bus.color), OW'(3'd1));
        bus.seed_load = 1'b0; bus.mode = 2'b00; bus.clk_en = 1'b1; bus.hold_cycles = 16'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rnd_color%0d", i), OW'(bus.color), OW'(rnd_col[i]));
            check($sformatf("rnd_stb%0d", i), OW'(bus.frame_stb), OW'(1'b1));
            check($sformatf("model_lfsr%0d", i), OW'(m_lfsr), OW'(rnd_lfsr[i]));
        end

        // CYCLE, hold 3, clk_en every other cycle
        bus.seed = 8'h04; bus.seed_load = 1'b1; bus.clk_en = 1'b0;
        tick();
        bus.seed_load = 1'b0; bus.mode = 2'b01; bus.hold_cycles = 16'd3;
        got = 0; dbl = 0; prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bus.clk_en = (i % 2 == 0);
            tick();
            if (bus.frame_stb) begin
                if (got < 4) check($sformatf("cyc_color%0d", got), OW'(bus.color), OW'(cyc_exp[got]));
                if (prev) dbl++;
                got++;
            end
            prev = bus.frame_stb;
        end
        check("cyc_advances", OW'(got), OW'(4));
        check("cyc_stb_single", OW'(dbl), '0);

        // seed 0 in RANDOM, then seed load coincident with an advance
        bus.mode = 2'b00; bus.seed = 8'h00; bus.seed_load = 1'b1; bus.clk_en = 1'b0;
        tick();
        check("seed0_color", OW'(bus.color), OW'(3'd7));
        check("seed0_model_lfsr", OW'(m_lfsr), OW'(1));
        bus.hold_cycles = 16'd1; bus.clk_en = 1'b1; bus.seed = 8'h33;
        tick();
        check("coinc_stb", OW'(bus.frame_stb), '0);
        check("coinc_color", OW'(bus.color), OW'(3'd3));
        bus.seed_load = 1'b0; bus.hold_cycles = 16'd3;
        tick(); check("coinc_cnt1", OW'(bus.frame_stb), '0);
        tick(); check("coinc_cnt2", OW'(bus.frame_stb), '0);
        tick(); check("coinc_adv", OW'(bus.frame_stb), OW'(1'b1));
        check("coinc_adv_color", OW'(bus.color), OW'(3'd6));

        // Smiley in green, then OFF
        bus.mode = 2'b10; bus.seed = 8'h02; bus.seed_load = 1'b1; bus.clk_en = 1'b0;
        tick();
        bus.seed_load = 1'b0;
        tick();
        check("smiley_row7", OW'(bus.out[7*24 +: 24]), OW'(24'h003C00));
        bus.mode = 2'b11; bus.clk_en = 1'b1; bus.hold_cycles = 16'd2;
        tick();
        check("off_out", bus.out, '0);
        tick(); tick(); tick();
        check("off_stb", OW'(bus.frame_stb), '0);
        bus.mode = 2'b00;
        tick(); check("resume_cnt", OW'(bus.frame_stb), '0);
        tick(); check("resume_adv", OW'(bus.frame_stb), OW'(1'b1));
        check("resume_color", OW'(bus.color), OW'(3'd4));
        bus.mode = 2'b11; bus.seed = 8'h07; bus.seed_load = 1'b1;
        tick();
        check("off_seed_load", OW'(bus.color), OW'(3'd7));
        bus.seed_load = 1'b0;

        // Lowering hold mid-count, and hold 0 as 1
        bus.mode = 2'b10; bus.hold_cycles = 16'd10; bus.seed = 8'h01; bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_no_adv", OW'(bus.frame_stb), '0);
        bus.hold_cycles = 16'd2;
        tick(); check("mid_lower_adv", OW'(bus.frame_stb), OW'(1'b1));
        bus.hold_cycles = 16'd0;
        tick(); check("hold0_a", OW'(bus.frame_stb), OW'(1'b1));
        tick(); check("hold0_b", OW'(bus.frame_stb), OW'(1'b1));

`ifdef SMILEY_BLINK_EN
        bus.hold_cycles = 16'd2; bus.seed = 8'h07; bus.seed_load = 1'b1; bus.blink = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("blink_%0d", i), OW'(bus.out == '0), OW'((i % 4 == 3) || (i % 4 == 0)));
        end
        bus.blink = 1'b0; blanks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out == '0) blanks++;
        end
        check("noblink", OW'(blanks), '0);
`endif

        bus.clk_en = 1'b0;
        tick(); tick();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
